// File: rtl/sdc_init_seq.sv
// rtl/sdc_init_seq.sv - SD SPI-mode card initialisation sequencer (CMD0, CMD8, CMD55/ACMD41, CMD16)
// Drives the SPI command engine one command at a time and reports ready or a coded failure.
module sdc_init_seq #(
    parameter int PWR_WAIT     = 1000,
    parameter int CMD0_TRIES   = 4,
    parameter int ACMD41_TRIES = 1000,
    parameter int RETRY_GAP    = 100,
    parameter int RESP_TIMEOUT = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic [7:0]  o_cmd,
    output logic [31:0] o_arg,
    output logic [7:0]  o_crc,
    output logic        o_we,
    input  logic        i_done,
    input  logic [7:0]  i_response,
    output logic        o_busy,
    output logic        o_ready,
    output logic        o_error,
    output logic [2:0]  o_err_code
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PWR   = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERROR = 3'd7;

    localparam logic [2:0] C_CMD0   = 3'd0;
    localparam logic [2:0] C_CMD8   = 3'd1;
    localparam logic [2:0] C_CMD55  = 3'd2;
    localparam logic [2:0] C_ACMD41 = 3'd3;
    localparam logic [2:0] C_CMD16  = 3'd4;

    // One shared timer serves power-up, response timeout and retry gap.
    localparam int MAX_A = (PWR_WAIT > RETRY_GAP) ? PWR_WAIT : RETRY_GAP;
    localparam int MAX_T = (MAX_A > RESP_TIMEOUT) ? MAX_A : RESP_TIMEOUT;
    localparam int TW    = $clog2(MAX_T + 1);
    localparam int C0W   = $clog2(CMD0_TRIES + 1);
    localparam int A41W  = $clog2(ACMD41_TRIES + 1);

    localparam logic [TW-1:0]   PWR_LAST = TW'(PWR_WAIT - 1);
    localparam logic [TW-1:0]   GAP_LAST = TW'(RETRY_GAP - 1);
    localparam logic [TW-1:0]   TO_LAST  = TW'(RESP_TIMEOUT - 1);
    localparam logic [C0W-1:0]  C0_MAX   = C0W'(CMD0_TRIES);
    localparam logic [A41W-1:0] A41_MAX  = A41W'(ACMD41_TRIES);

    logic [2:0]      state;
    logic [2:0]      sel;
    logic [TW-1:0]   timer;
    logic [C0W-1:0]  cmd0_cnt;
    logic [A41W-1:0] acmd_cnt;
    logic [7:0]      r1;
    logic [C0W-1:0]  cmd0_next;
    logic [A41W-1:0] acmd_next;
    logic [7:0]      tbl_cmd;
    logic [31:0]     tbl_arg;
    logic [7:0]      tbl_crc;

    assign cmd0_next = cmd0_cnt + C0W'(1);
    assign acmd_next = acmd_cnt + A41W'(1);
    assign o_busy    = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);

    always_comb begin
        tbl_cmd = 8'h40;
        tbl_arg = 32'h0000_0000;
        tbl_crc = 8'h95;
        case (sel)
            C_CMD8:   begin tbl_cmd = 8'h48; tbl_arg = 32'h0000_01AA; tbl_crc = 8'h87; end
            C_CMD55:  begin tbl_cmd = 8'h77; tbl_arg = 32'h0000_0000; tbl_crc = 8'h65; end
            C_ACMD41: begin tbl_cmd = 8'h69; tbl_arg = 32'h4000_0000; tbl_crc = 8'h77; end
            C_CMD16:  begin tbl_cmd = 8'h50; tbl_arg = 32'h0000_0200; tbl_crc = 8'h15; end
            default:  begin tbl_cmd = 8'h40; tbl_arg = 32'h0000_0000; tbl_crc = 8'h95; end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            sel        <= C_CMD0;
            timer      <= '0;
            cmd0_cnt   <= '0;
            acmd_cnt   <= '0;
            r1         <= 8'h00;
            o_cmd      <= 8'h00;
            o_arg      <= 32'h0000_0000;
            o_crc      <= 8'h00;
            o_we       <= 1'b0;
            o_ready    <= 1'b0;
            o_error    <= 1'b0;
            o_err_code <= 3'd0;
        end else begin
            o_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        state      <= S_PWR;
                        timer      <= '0;
                        cmd0_cnt   <= '0;
                        acmd_cnt   <= '0;
                        o_ready    <= 1'b0;
                        o_error    <= 1'b0;
                        o_err_code <= 3'd0;
                    end
                end
                S_PWR: begin
                    if (timer == PWR_LAST) begin
                        sel   <= C_CMD0;
                        state <= S_ISSUE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_ISSUE: begin
                    o_cmd <= tbl_cmd;
                    o_arg <= tbl_arg;
                    o_crc <= tbl_crc;
                    o_we  <= 1'b1;
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_done) begin
                        r1    <= i_response;
                        state <= S_CHECK;
                    end else if (timer == TO_LAST) begin
                        state      <= S_ERROR;
                        o_error    <= 1'b1;
                        o_err_code <= 3'd6;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_CHECK: begin
                    case (sel)
                        C_CMD0: begin
                            if (r1 == 8'h01) begin
                                sel   <= C_CMD8;
                                state <= S_ISSUE;
                            end else if (cmd0_next == C0_MAX) begin
                                state      <= S_ERROR;
                                o_error    <= 1'b1;
                                o_err_code <= 3'd1;
                            end else begin
                                cmd0_cnt <= cmd0_next;
                                state    <= S_ISSUE;
                            end
                        end
                        C_CMD8: begin
                            if (r1 == 8'h01) begin
                                sel   <= C_CMD55;
                                state <= S_ISSUE;
                            end else begin
                                state      <= S_ERROR;
                                o_error    <= 1'b1;
                                o_err_code <= 3'd2;
                            end
                        end
                        C_CMD55: begin
                            if (r1 == 8'h01 || r1 == 8'h00) begin
                                sel   <= C_ACMD41;
                                state <= S_ISSUE;
                            end else begin
                                state      <= S_ERROR;
                                o_error    <= 1'b1;
                                o_err_code <= 3'd3;
                            end
                        end
                        C_ACMD41: begin
                            if (r1 == 8'h00) begin
                                sel   <= C_CMD16;
                                state <= S_ISSUE;
                            end else if (r1 == 8'h01 && acmd_next != A41_MAX) begin
                                acmd_cnt <= acmd_next;
                                timer    <= '0;
                                state    <= S_GAP;
                            end else begin
                                acmd_cnt   <= acmd_next;
                                state      <= S_ERROR;
                                o_error    <= 1'b1;
                                o_err_code <= 3'd4;
                            end
                        end
                        C_CMD16: begin
                            if (r1 == 8'h00) begin
                                state   <= S_DONE;
                                o_ready <= 1'b1;
                            end else begin
                                state      <= S_ERROR;
                                o_error    <= 1'b1;
                                o_err_code <= 3'd5;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
                S_GAP: begin
                    if (timer == GAP_LAST) begin
                        sel   <= C_CMD55;
                        state <= S_ISSUE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sdc_init_seq.md
Name: sdc_init_seq

Overview:
Command sequencer that sits directly upstream of the SPI SD-card command engine. It drives that engine's command/argument/CRC/write-enable inputs and consumes its done strobe and R1 response byte. On i_start it runs the SD SPI-mode initialisation sequence (CMD0, CMD8, CMD55/ACMD41 loop, CMD16) and reports ready or a coded error. Downstream read/write blocks wait for o_ready before using the card.

Parameters:
PWR_WAIT, 1000, idle cycles after i_start before the first command (card power-up settling)
CMD0_TRIES, 4, maximum CMD0 attempts before error
ACMD41_TRIES, 1000, maximum CMD55+ACMD41 pairs before error
RETRY_GAP, 100, idle cycles between ACMD41 attempts
RESP_TIMEOUT, 100000, cycles from o_we to i_done before a timeout error

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, synchronous, active-low
i_start  in  1  start pulse; honoured only in IDLE, DONE or ERROR
o_cmd  out  8  command byte to engine (0x40|index)
o_arg  out  32  argument to engine
o_crc  out  8  CRC byte to engine
o_we  out  1  one-cycle issue strobe to engine
i_done  in  1  engine completion pulse
i_response  in  8  engine R1 byte, valid when i_done=1
o_busy  out  1  sequence in progress
o_ready  out  1  card initialised; held until reset or next i_start
o_error  out  1  sequence failed; held until reset or next i_start
o_err_code  out  3  failure cause, valid while o_error=1

Behaviour:
- Clock and reset: one clock i_clk; reset is synchronous and active-low (i_rst_n sampled on the rising edge of i_clk). Reset values: o_cmd=0, o_arg=0, o_crc=0, o_we=0, o_busy=0, o_ready=0, o_error=0, o_err_code=0; all counters=0; state=IDLE. Reset mid-sequence returns to IDLE immediately. The engine is not aborted by this block, so the system resets both blocks together.
- Command table (cmd/arg/crc):
  CMD0 = 0x40 / 0x00000000 / 0x95
  CMD8 = 0x48 / 0x000001AA / 0x87
  CMD55 = 0x77 / 0x00000000 / 0x65
  ACMD41 = 0x69 / 0x40000000 / 0x77
  CMD16 = 0x50 / 0x00000200 / 0x15
- States:
  IDLE -> PWR on i_start.
  PWR counts PWR_WAIT cycles, then goes to ISSUE(CMD0).
  ISSUE drives o_cmd/o_arg/o_crc and pulses o_we for exactly one cycle, then goes to WAIT.
  WAIT: on i_done, latch i_response and go to CHECK. If RESP_TIMEOUT cycles elapse without i_done, go to ERROR with code 6.
  CHECK applies the per-command rule below.
  GAP counts RETRY_GAP cycles, then goes to ISSUE(CMD55).
  DONE and ERROR are terminal; i_start restarts from PWR and clears o_ready, o_error and o_err_code.
- o_cmd, o_arg and o_crc stay stable from the o_we cycle until i_done. o_we is never asserted while a command is outstanding.
- o_busy=1 in every state except IDLE, DONE and ERROR. i_start is ignored while o_busy=1. i_done outside WAIT is ignored.
- CHECK rules (R1 = latched i_response):
  CMD0: R1=0x01 -> CMD8. Otherwise retry CMD0; after CMD0_TRIES failed attempts -> ERROR code 1.
  CMD8: R1=0x01 -> CMD55. Any other value, including 0x05 (v1 card) -> ERROR code 2.
  CMD55: R1 = 0x01 or 0x00 -> ACMD41. Otherwise -> ERROR code 3.
  ACMD41: R1=0x00 -> CMD16. R1=0x01 -> increment the attempt counter; if the counter equals ACMD41_TRIES -> ERROR code 4, else go to GAP. Any other value -> ERROR code 4.
  CMD16: R1=0x00 -> DONE with o_ready=1. Otherwise -> ERROR code 5.
- Counters are sized to hold their parameter value and are cleared on each use. Attempt counters are cleared on i_start.
- Latency with zero-wait engine: o_we for CMD0 asserts PWR_WAIT+1 cycles after i_start is sampled.

Test Plan:
- PWR_WAIT=4; engine model answers 0x01,0x01,0x01,0x00,0x00 -> o_we issues CMD0,CMD8,CMD55,ACMD41,CMD16 with the table values; o_ready=1, o_busy=0, o_error=0.
- ACMD41 answers 0x01 three times then 0x00, RETRY_GAP=5 -> four CMD55/ACMD41 pairs, at least 5 idle cycles between pairs, then CMD16 and o_ready=1.
- CMD0 answers 0xFF every time, CMD0_TRIES=4 -> exactly 4 CMD0 issues; o_error=1, o_err_code=1.
- CMD8 answers 0x05 -> o_error=1, o_err_code=2; no CMD55 issued.
- Engine never returns i_done, RESP_TIMEOUT=50 -> o_error=1, o_err_code=6 at 50 cycles after o_we.
- Reset asserted (i_rst_n=0) during ACMD41 wait, then i_start -> all outputs at reset values; the sequence restarts at CMD0; o_we never asserted twice without an intervening i_done.
